// File: rtl/ate_pkg.sv
// Shared constants and state encoding for the adaptive-threshold scan sequencer.
package ate_pkg;

  localparam int unsigned BLK_DIM = 8;
  localparam int unsigned BLK_PIX = 64;
  localparam int unsigned PIX_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ate_blk_addr_gen.sv
// Block-order address generator: pixel/block-column/block-row counters and
// the memory address and block flags for the current scan position.
module ate_blk_addr_gen
  import ate_pkg::*;
#(
  parameter int unsigned BLK_COLS = 6,
  parameter int unsigned BLK_ROWS = 4,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] addr_c,
  output logic              first_c,
  output logic              last_c,
  output logic              border_c,
  output logic              frame_last_c
);

  localparam int unsigned BC_W    = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
  localparam int unsigned BR_W    = (BLK_ROWS > 1) ? $clog2(BLK_ROWS) : 1;
  localparam int unsigned ROW_PIX = BLK_DIM * BLK_COLS;

  logic [PIX_W-1:0]  p_q, p_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [BR_W-1:0]   br_q, br_d;
  logic [ADDR_W-1:0] row_c;
  logic              last_col_c;
  logic              last_row_c;

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q  <= '0;
      bc_q <= '0;
      br_q <= '0;
    end else begin
      p_q  <= p_d;
      bc_q <= bc_d;
      br_q <= br_d;
    end
  end

  // Position flags for the current counter values.
  always_comb begin
    first_c      = (p_q == '0);
    last_c       = (p_q == PIX_W'(BLK_PIX - 1));
    last_col_c   = (bc_q == BC_W'(BLK_COLS - 1));
    last_row_c   = (br_q == BR_W'(BLK_ROWS - 1));
    border_c     = (bc_q == '0) || last_col_c;
    frame_last_c = last_c && last_col_c && last_row_c;
  end

  // Nested counter advance: pixel, then block column, then block row.
  always_comb begin
    p_d  = p_q;
    bc_d = bc_q;
    br_d = br_q;
    if (clear_i) begin
      p_d  = '0;
      bc_d = '0;
      br_d = '0;
    end else if (advance_i) begin
      if (last_c) begin
        p_d = '0;
        if (last_col_c) begin
          bc_d = '0;
          br_d = last_row_c ? '0 : br_q + BR_W'(1);
        end else begin
          bc_d = bc_q + BC_W'(1);
        end
      end else begin
        p_d = p_q + PIX_W'(1);
      end
    end
  end

  // Linear address: image row times row pitch plus image column.
  always_comb begin
    row_c  = ADDR_W'(br_q) * ADDR_W'(BLK_DIM) + ADDR_W'(p_q[5:3]);
    addr_c = row_c * ADDR_W'(ROW_PIX) + ADDR_W'(bc_q) * ADDR_W'(BLK_DIM)
           + ADDR_W'(p_q[2:0]);
  end

endmodule

// File: rtl/ate_scan_ctrl.sv
// Scan sequencer: start/busy/done handshake, stall-aware read issue and a
// one-stage sideband delay aligning flags with the memory read data.
module ate_scan_ctrl
  import ate_pkg::*;
#(
  parameter int unsigned BLK_COLS = 6,
  parameter int unsigned BLK_ROWS = 4,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pix_valid,
  output logic              blk_first,
  output logic              blk_last,
  output logic              border,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              iss_first_q, iss_first_d;
  logic              iss_last_q, iss_last_d;
  logic              iss_border_q, iss_border_d;
  logic              pix_valid_q, blk_first_q, blk_last_q, border_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear_c, advance_c;
  logic [ADDR_W-1:0] addr_c;
  logic              first_c, last_c, border_c, frame_last_c;

  ate_blk_addr_gen #(
    .BLK_COLS (BLK_COLS),
    .BLK_ROWS (BLK_ROWS),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (clear_c),
    .advance_i    (advance_c),
    .addr_c       (addr_c),
    .first_c      (first_c),
    .last_c       (last_c),
    .border_c     (border_c),
    .frame_last_c (frame_last_c)
  );

  // State, issue-stage and sideband registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      iss_first_q  <= 1'b0;
      iss_last_q   <= 1'b0;
      iss_border_q <= 1'b0;
      pix_valid_q  <= 1'b0;
      blk_first_q  <= 1'b0;
      blk_last_q   <= 1'b0;
      border_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      iss_first_q  <= iss_first_d;
      iss_last_q   <= iss_last_d;
      iss_border_q <= iss_border_d;
      pix_valid_q  <= mem_rd_q;
      blk_first_q  <= mem_rd_q & iss_first_q;
      blk_last_q   <= mem_rd_q & iss_last_q;
      border_q     <= mem_rd_q & iss_border_q;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Next-state and issue logic; DRAIN waits for the last read to reach pix_valid.
  always_comb begin
    state_d      = state_q;
    mem_rd_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    iss_first_d  = 1'b0;
    iss_last_d   = 1'b0;
    iss_border_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    clear_c      = 1'b0;
    advance_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          clear_c = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          mem_rd_d     = 1'b1;
          mem_addr_d   = addr_c;
          iss_first_d  = first_c;
          iss_last_d   = last_c;
          iss_border_d = border_c;
          advance_c    = 1'b1;
          if (frame_last_c) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!mem_rd_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_rd    = mem_rd_q;
  assign mem_addr  = mem_addr_q;
  assign pix_valid = pix_valid_q;
  assign blk_first = blk_first_q;
  assign blk_last  = blk_last_q;
  assign border    = border_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ate_scan_ctrl.sv
// Self-checking bench for ate_scan_ctrl: per-cycle comparison against an
// image-coordinate reference model, with directed and random stall/start stimulus.
module tb_ate_scan_ctrl;

  localparam int unsigned BLK_COLS = 6;
  localparam int unsigned BLK_ROWS = 4;
  localparam int unsigned ADDR_W   = 11;
  localparam int N     = 64 * BLK_COLS * BLK_ROWS;
  localparam int IMG_W = 8 * BLK_COLS;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stall;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              pix_valid, blk_first, blk_last, border, busy, done;

  int errors = 0;
  int checks = 0;

  int obs_addr   [N];
  bit obs_first  [N];
  bit obs_last   [N];
  bit obs_border [N];

  ate_scan_ctrl #(
    .BLK_COLS (BLK_COLS),
    .BLK_ROWS (BLK_ROWS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stall     (stall),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .pix_valid (pix_valid),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .border    (border),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: k-th pixel in block scan order mapped to image (x, y).
  function automatic int ref_addr(input int k);
    int blk, p, x, y;
    blk = k / 64;
    p   = k % 64;
    x   = (blk % BLK_COLS) * 8 + (p % 8);
    y   = (blk / BLK_COLS) * 8 + (p / 8);
    return y * IMG_W + x;
  endfunction

  function automatic bit ref_border(input int k);
    int col;
    col = (k / 64) % BLK_COLS;
    return (col == 0) || (col == BLK_COLS - 1);
  endfunction

  // Runs one frame, checking every cycle against the model; returns done edge.
  task automatic run_frame(input int stall_at, input int stall_len,
                           input bit rnd_stall, input bit noise_start,
                           output int done_edge);
    int rd_idx, stalls, edge_n, left, cur_idx, prev_idx, exp_addr, obs_n, pv_n;
    bit st, exp_rd, prev_rd, got_done, exp_done, exp_busy;
    rd_idx = 0; stalls = 0; edge_n = 0; left = stall_len; cur_idx = 0;
    prev_idx = 0; exp_addr = 0; obs_n = 0; pv_n = 0;
    exp_rd = 1'b0; got_done = 1'b0; done_edge = -1;
    start = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_entry busy=%0b mem_rd=%0b pix_valid=%0b exp 1/0/0",
               busy, mem_rd, pix_valid);
    end
    while (!got_done && edge_n < 4 * N) begin
      if (rd_idx == stall_at && left > 0) begin
        st = 1'b1;
        left--;
      end else if (rnd_stall) begin
        st = ($urandom_range(0, 3) == 0);
      end else begin
        st = 1'b0;
      end
      stall = st;
      if (noise_start) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      edge_n++;
      prev_rd  = exp_rd;
      prev_idx = cur_idx;
      if (rd_idx < N) begin
        if (st) begin
          exp_rd = 1'b0;
          stalls++;
        end else begin
          exp_rd   = 1'b1;
          cur_idx  = rd_idx;
          exp_addr = ref_addr(rd_idx);
          rd_idx++;
        end
      end else begin
        exp_rd = 1'b0;
      end
      exp_done = (edge_n == N + 2 + stalls);
      exp_busy = (edge_n < N + 2 + stalls);

      checks++;
      if (mem_rd !== exp_rd) begin
        errors++;
        $display("FAIL mem_rd edge=%0d got=%0b exp=%0b", edge_n, mem_rd, exp_rd);
      end
      if (exp_rd || (st && rd_idx > 0 && rd_idx < N)) begin
        checks++;
        if (mem_addr !== ADDR_W'(exp_addr)) begin
          errors++;
          $display("FAIL mem_addr edge=%0d got=%0d exp=%0d", edge_n, mem_addr, exp_addr);
        end
      end
      checks++;
      if (pix_valid !== prev_rd) begin
        errors++;
        $display("FAIL pix_valid edge=%0d got=%0b exp=%0b", edge_n, pix_valid, prev_rd);
      end
      checks++;
      if (blk_first !== (prev_rd && (prev_idx % 64 == 0)) ||
          blk_last  !== (prev_rd && (prev_idx % 64 == 63)) ||
          border    !== (prev_rd && ref_border(prev_idx))) begin
        errors++;
        $display("FAIL flags edge=%0d got first=%0b last=%0b border=%0b for pixel %0d valid=%0b",
                 edge_n, blk_first, blk_last, border, prev_idx, prev_rd);
      end
      checks++;
      if (done !== exp_done || busy !== exp_busy) begin
        errors++;
        $display("FAIL done_busy edge=%0d got done=%0b busy=%0b exp done=%0b busy=%0b",
                 edge_n, done, busy, exp_done, exp_busy);
      end

      if (mem_rd === 1'b1) begin
        if (obs_n < N) obs_addr[obs_n] = int'(mem_addr);
        obs_n++;
      end
      if (pix_valid === 1'b1) begin
        if (pv_n < N) begin
          obs_first[pv_n]  = blk_first;
          obs_last[pv_n]   = blk_last;
          obs_border[pv_n] = border;
        end
        pv_n++;
      end
      if (done === 1'b1) begin
        got_done  = 1'b1;
        done_edge = edge_n;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL done_timeout no done within %0d edges", edge_n);
    end
    checks++;
    if (obs_n != N || pv_n != N) begin
      errors++;
      $display("FAIL pulse_count reads=%0d pix_valid=%0d exp %0d", obs_n, pv_n, N);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%0b busy=%0b exp 0/0", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after busy=%0b mem_rd=%0b pix_valid=%0b exp 0", busy, mem_rd, pix_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({mem_rd, pix_valid, blk_first, blk_last, border, busy, done} !== 7'b0 ||
        mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_state rd=%0b addr=%0d pv=%0b f=%0b l=%0b b=%0b busy=%0b done=%0b exp all 0",
               mem_rd, mem_addr, pix_valid, blk_first, blk_last, border, busy, done);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL reset_start_idle busy=%0b mem_rd=%0b exp 0/0", busy, mem_rd);
      end
    end
  endtask

  task automatic test_nominal();
    int de;
    run_frame(-1, 0, 1'b0, 1'b0, de);
    checks++;
    if (de != N + 2) begin
      errors++;
      $display("FAIL nominal_done_edge got=%0d exp=1538", de);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_addr[i] != i || obs_addr[i + 8] != 48 + i) begin
        errors++;
        $display("FAIL first_rows read %0d got=%0d/%0d exp=%0d/%0d",
                 i, obs_addr[i], obs_addr[i + 8], i, 48 + i);
      end
    end
    checks++;
    if (obs_addr[63] != 343 || obs_last[63] !== 1'b1) begin
      errors++;
      $display("FAIL blk_boundary_last got addr=%0d last=%0b exp 343/1", obs_addr[63], obs_last[63]);
    end
    checks++;
    if (obs_addr[64] != 8 || obs_first[64] !== 1'b1) begin
      errors++;
      $display("FAIL blk_boundary_first got addr=%0d first=%0b exp 8/1", obs_addr[64], obs_first[64]);
    end
    checks++;
    if (obs_border[0] !== 1'b1 || obs_border[64] !== 1'b0) begin
      errors++;
      $display("FAIL border_cols got col0=%0b col1=%0b exp 1/0", obs_border[0], obs_border[64]);
    end
    checks++;
    if (obs_addr[384] != 384) begin
      errors++;
      $display("FAIL row_wrap got=%0d exp=384", obs_addr[384]);
    end
    checks++;
    if (obs_addr[N - 1] != 1535 || obs_last[N - 1] !== 1'b1 || obs_border[N - 1] !== 1'b1) begin
      errors++;
      $display("FAIL frame_last got addr=%0d last=%0b border=%0b exp 1535/1/1",
               obs_addr[N - 1], obs_last[N - 1], obs_border[N - 1]);
    end
  endtask

  task automatic test_stall();
    int de;
    run_frame(128 + 20, 3, 1'b0, 1'b0, de);
    checks++;
    if (de != N + 5) begin
      errors++;
      $display("FAIL stall_done_edge got=%0d exp=1541", de);
    end
    checks++;
    if (obs_addr[147] != ref_addr(147) || obs_addr[148] != ref_addr(148)) begin
      errors++;
      $display("FAIL stall_seq got=%0d,%0d exp=%0d,%0d",
               obs_addr[147], obs_addr[148], ref_addr(147), ref_addr(148));
    end
  endtask

  task automatic test_start_while_busy();
    int de;
    run_frame(-1, 0, 1'b1, 1'b1, de);
  endtask

  task automatic test_random_stall();
    int de;
    run_frame(-1, 0, 1'b1, 1'b0, de);
  endtask

  task automatic test_mid_reset();
    int de;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (mem_rd !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_run got mem_rd=%0b busy=%0b exp 1/1", mem_rd, busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (mem_rd !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rd=%0b pv=%0b busy=%0b done=%0b exp 0",
               mem_rd, pix_valid, busy, done);
    end
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle done=%0b busy=%0b pv=%0b exp 0", done, busy, pix_valid);
      end
    end
    run_frame(-1, 0, 1'b0, 1'b0, de);
    checks++;
    if (obs_addr[0] != 0 || de != N + 2) begin
      errors++;
      $display("FAIL restart got first=%0d done_edge=%0d exp 0/1538", obs_addr[0], de);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    test_reset();
    test_nominal();
    test_stall();
    test_start_while_busy();
    test_mid_reset();
    test_random_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
